spi_flash_reader: RTL and testbench

//  Single-word SPI flash read initiator (mode 0, single-bit I/O, command 0x03).

---
 rtl/spi_flash_reader_if.sv | 26 ++
 rtl/spi_flash_reader.sv | 133 +++++++++++++
 tb/tb_spi_flash_reader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_reader_if.sv
// Request/response handshake and flash pad bundle for spi_flash_reader.
// The master side is the management core plus the flash device; the slave side is the reader.
interface spi_flash_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        flash_csb;
  logic        flash_clk;
  logic        flash_io0_do;
  logic        flash_io0_oeb;
  logic        flash_io1_di;

  modport master (
    output req_valid, req_addr, flash_io1_di,
    input  req_ready, rsp_valid, rsp_data,
           flash_csb, flash_clk, flash_io0_do, flash_io0_oeb
  );

  modport slave (
    input  req_valid, req_addr, flash_io1_di,
    output req_ready, rsp_valid, rsp_data,
           flash_csb, flash_clk, flash_io0_do, flash_io0_oeb
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 single-word flash reader: sends opcode + 24-bit address, shifts in
// 4 bytes and returns them as a little-endian 32-bit word.
module spi_flash_reader #(
  parameter int          CLK_DIV     = 1,
  parameter logic [7:0]  CMD_READ    = 8'h03,
  parameter int          CS_HIGH_MIN = 2
) (
  input  logic               core_clk,
  input  logic               core_rst,
  spi_flash_reader_if.slave  bus
);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(CS_HIGH_MIN + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [6:0]         bit_q, bit_d;
  logic               clk_q, clk_d;
  logic               csb_q, csb_d;
  logic               oeb_q, oeb_d;
  logic               do_q, do_d;
  logic [31:0]        tx_q, tx_d;
  logic [31:0]        rx_q, rx_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               tick;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    gap_d       = gap_q;
    bit_d       = bit_q;
    clk_d       = clk_q;
    csb_d       = csb_q;
    oeb_d       = oeb_q;
    do_d        = do_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = CMD;
          tx_d    = {CMD_READ, bus.req_addr};
        end
      end
      CMD, ADDR, DATA: begin
        // First cycle after accept: chip select still high, open the frame.
        if (csb_q) begin
          csb_d = 1'b0;
          oeb_d = 1'b0;
          do_d  = tx_q[31];
          clk_d = 1'b0;
          div_d = '0;
          bit_d = '0;
        end else if (!tick) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (!clk_q) begin
            clk_d = 1'b1;
            if (state_q == DATA) rx_d = {rx_q[30:0], bus.flash_io1_di};
          end else if (bit_q == 7'd63) begin
            clk_d       = 1'b0;
            csb_d       = 1'b1;
            oeb_d       = 1'b1;
            do_d        = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
            state_d     = GAP;
            gap_d       = '0;
          end else begin
            clk_d = 1'b0;
            bit_d = bit_q + 7'd1;
            tx_d  = {tx_q[30:0], 1'b0};
            do_d  = (bit_q < 7'd31) ? tx_q[30] : 1'b0;
            if (bit_q == 7'd7)  state_d = ADDR;
            if (bit_q == 7'd31) state_d = DATA;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(CS_HIGH_MIN - 1)) state_d = IDLE;
        else gap_d = gap_q + GAP_W'(1);
      end
      default: state_d = GAP;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q     <= GAP;
      div_q       <= '0;
      gap_q       <= '0;
      bit_q       <= '0;
      clk_q       <= 1'b0;
      csb_q       <= 1'b1;
      oeb_q       <= 1'b1;
      do_q        <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
      bit_q       <= bit_d;
      clk_q       <= clk_d;
      csb_q       <= csb_d;
      oeb_q       <= oeb_d;
      do_q        <= do_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.flash_csb     = csb_q;
  assign bus.flash_clk     = clk_q;
  assign bus.flash_io0_do  = do_q;
  assign bus.flash_io0_oeb = oeb_q;
endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI flash model, table + random reads,
// back-to-back, mid-frame reset, and a CLK_DIV=3 instance for timing.
module tb_spi_flash_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_flash_reader_if b1 ();
  spi_flash_reader_if b2 ();

  spi_flash_reader #(.CLK_DIV(1), .CMD_READ(8'h03), .CS_HIGH_MIN(2)) dut1 (
    .core_clk(clk), .core_rst(rst), .bus(b1.slave));
  spi_flash_reader #(.CLK_DIV(3), .CMD_READ(8'h03), .CS_HIGH_MIN(2)) dut2 (
    .core_clk(clk), .core_rst(rst), .bus(b2.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Flash contents: explicit bytes, otherwise a fixed hash of the address.
  logic [7:0] mem [logic [23:0]];
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] ref_word(input logic [23:0] a);
    return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
  endfunction

  // Flash model on b1: shift in 32 command/address bits, then shift out bytes.
  int          rises = 0;
  logic [31:0] cap = '0;
  always @(negedge b1.flash_csb) rises = 0;
  always @(posedge b1.flash_clk) begin
    if (!b1.flash_csb) begin
      rises++;
      if (rises <= 32) cap = {cap[30:0], b1.flash_io0_do};
    end
  end
  always @(negedge b1.flash_clk) begin
    logic [7:0] bt;
    int j;
    if (!b1.flash_csb && rises >= 32 && rises < 64) begin
      j  = rises - 32;
      bt = fbyte(cap[23:0] + 24'(j / 8));
      b1.flash_io1_di = bt[7 - (j % 8)];
    end
  end

  assign b2.flash_io1_di = 1'b1;

  int np1 = 0;
  int np2 = 0;
  always @(negedge clk) begin
    if (b1.rsp_valid) np1++;
    if (b2.rsp_valid) np2++;
  end

  // flash_clk phase lengths on the CLK_DIV=3 instance while selected.
  int   run2 = 0, nr2 = 0, rmin2 = 999, rmax2 = 0;
  logic pclk2 = 1'b0;
  always @(negedge clk) begin
    if (b2.flash_csb) run2 = 0;
    else if (b2.flash_clk == pclk2) run2++;
    else begin
      nr2++;
      if (run2 < rmin2) rmin2 = run2;
      if (run2 > rmax2) rmax2 = run2;
      run2 = 1;
    end
    pclk2 = b2.flash_clk;
  end

  // Called at a negedge; returns edges from accept to rsp_valid.
  task automatic do_read(input logic [23:0] a, output logic [31:0] d, output int lat, output bit ok);
    int t;
    ok = 0; t = 0; lat = 0; d = '0;
    while (!b1.req_ready && t < 1000) begin @(negedge clk); t++; end
    b1.req_valid = 1'b1;
    b1.req_addr  = a;
    @(posedge clk);
    @(negedge clk);
    b1.req_valid = 1'b0;
    t = 0;
    while (t < 2000) begin
      @(negedge clk);
      lat++; t++;
      if (b1.rsp_valid) begin d = b1.rsp_data; ok = 1; break; end
    end
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [23:0] a;
    int lat, p0, hi, pulses, t;
    bit ok;

    b1.req_valid = 1'b0; b1.req_addr = '0;
    b2.req_valid = 1'b0; b2.req_addr = '0;
    mem[24'h000010] = 8'h11; mem[24'h000011] = 8'h22; mem[24'h000012] = 8'h33; mem[24'h000013] = 8'h44;
    mem[24'h000100] = 8'hDE; mem[24'h000101] = 8'hAD; mem[24'h000102] = 8'hBE; mem[24'h000103] = 8'hEF;
    mem[24'hFFFFFC] = 8'h01; mem[24'hFFFFFD] = 8'h02; mem[24'hFFFFFE] = 8'h03; mem[24'hFFFFFF] = 8'h04;
    mem[24'h00ABC0] = 8'h00; mem[24'h00ABC1] = 8'hFF; mem[24'h00ABC2] = 8'h00; mem[24'h00ABC3] = 8'hFF;
    tbl[0] = '{24'h000010, 32'h44332211};
    tbl[1] = '{24'h000100, 32'hEFBEADDE};
    tbl[2] = '{24'hFFFFFC, 32'h04030201};
    tbl[3] = '{24'h00ABC0, 32'hFF00FF00};

    // Reset held 3 cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_csb", b1.flash_csb, 1);
    chk("rst_clk", b1.flash_clk, 0);
    chk("rst_do", b1.flash_io0_do, 0);
    chk("rst_oeb", b1.flash_io0_oeb, 1);
    chk("rst_rsp_valid", b1.rsp_valid, 0);
    chk("rst_rsp_data", b1.rsp_data, 0);
    chk("rst_ready", b1.req_ready, 0);
    chk("rst_csb2", b2.flash_csb, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after1", b1.req_ready, 0);
    @(negedge clk);
    chk("ready_after2", b1.req_ready, 1);

    // Table-driven reads: data, latency, serialised header, rise count, single pulse
    foreach (tbl[i]) begin
      p0 = np1;
      do_read(tbl[i].addr, d, lat, ok);
      chk("tbl_done", ok, 1);
      chk("tbl_data", d, tbl[i].exp);
      chk("tbl_lat", 32'(lat), 32'd129);
      chk("tbl_hdr", cap, {8'h03, tbl[i].addr});
      chk("tbl_rises", 32'(rises), 32'd64);
      @(negedge clk);
      chk("tbl_csb_end", b1.flash_csb, 1);
      chk("tbl_oeb_end", b1.flash_io0_oeb, 1);
      chk("tbl_hold", b1.rsp_data, tbl[i].exp);
      chk("tbl_pulses", 32'(np1 - p0), 32'd1);
    end

    // Random addresses against the reference word
    for (int i = 0; i < 6; i++) begin
      a = 24'($urandom);
      do_read(a, d, lat, ok);
      chk("rnd_done", ok, 1);
      chk("rnd_data", d, ref_word(a));
      chk("rnd_hdr", cap, {8'h03, a});
    end

    // req_valid held for two reads
    t = 0;
    while (!b1.req_ready && t < 1000) begin @(negedge clk); t++; end
    p0 = np1; pulses = 0; hi = 0;
    b1.req_valid = 1'b1; b1.req_addr = 24'h000010;
    t = 0;
    while (pulses < 2 && t < 1000) begin
      @(negedge clk); t++;
      if (b1.rsp_valid) begin
        pulses++;
        chk("b2b_data", b1.rsp_data, 32'h44332211);
        if (pulses == 2) b1.req_valid = 1'b0;
      end
      if (pulses == 1 && b1.flash_csb) hi++;
    end
    b1.req_valid = 1'b0;
    chk("b2b_seen", 32'(pulses), 32'd2);
    chk("b2b_gap_ok", (hi >= 2), 1);
    repeat (300) @(negedge clk);
    chk("b2b_pulses", 32'(np1 - p0), 32'd2);

    // Reset during ADDR bit 10
    t = 0;
    while (!b1.req_ready && t < 1000) begin @(negedge clk); t++; end
    b1.req_valid = 1'b1; b1.req_addr = 24'h000100;
    @(posedge clk);
    @(negedge clk);
    b1.req_valid = 1'b0;
    p0 = np1; t = 0;
    while (rises != 18 && t < 1000) begin @(negedge clk); t++; end
    chk("abort_reached", (rises == 18), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_csb", b1.flash_csb, 1);
    chk("abort_clk", b1.flash_clk, 0);
    chk("abort_oeb", b1.flash_io0_oeb, 1);
    chk("abort_valid", b1.rsp_valid, 0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_no_rsp", 32'(np1 - p0), 32'd0);
    do_read(24'h000010, d, lat, ok);
    chk("abort_redo_done", ok, 1);
    chk("abort_redo_data", d, 32'h44332211);

    // CLK_DIV=3 instance, MISO tied high
    t = 0;
    while (!b2.req_ready && t < 1000) begin @(negedge clk); t++; end
    b2.req_valid = 1'b1; b2.req_addr = 24'h000000;
    @(posedge clk);
    @(negedge clk);
    b2.req_valid = 1'b0;
    lat = 0; ok = 0; t = 0; d = '0;
    while (t < 2000) begin
      @(negedge clk); lat++; t++;
      if (b2.rsp_valid) begin d = b2.rsp_data; ok = 1; break; end
    end
    chk("div3_done", ok, 1);
    chk("div3_lat", 32'(lat), 32'd385);
    chk("div3_data", d, 32'hFFFFFFFF);
    chk("div3_nphase", 32'(nr2), 32'd127);
    chk("div3_phase_min", 32'(rmin2), 32'd3);
    chk("div3_phase_max", 32'(rmax2), 32'd3);
    repeat (5) @(negedge clk);
    chk("div3_pulses", 32'(np2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
